// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD instruction sequencer.
// Rev 1.0
`default_nettype none

package lcd_pkg;

  localparam int DLY_W = 27;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_SEND_HI,
    S_SEND_LO,
    S_CLEAR,
    S_ADVANCE,
    S_REFRESH_WAIT
  } seq_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_EN,
    W_WAIT
  } wr_state_e;

  localparam logic [7:0] DDRAM_LINE0 = 8'h80;
  localparam logic [7:0] DDRAM_LINE1 = 8'hC0;
  localparam logic       RS_CMD      = 1'b0;
  localparam logic       RS_DATA     = 1'b1;

  // Power-on handshake nibbles: 0x3, 0x3, 0x3, then 0x2 to select 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: one nibble on the LCD bus (setup, E strobe, post wait), or a silent wait.
// Rev 1.0
`default_nettype none

module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             quiet_i,
  input  logic [3:0]       nibble_i,
  input  logic             rs_i,
  input  logic [DLY_W-1:0] post_delay_i,
  output logic             lcd_e_o,
  output logic             lcd_rs_o,
  output logic [3:0]       lcd_d_o,
  output logic             done_o
);

  localparam logic [DLY_W-1:0] D_SETUP = DLY_W'(T_SETUP - 1);
  localparam logic [DLY_W-1:0] D_EN    = DLY_W'(T_EN - 1);
  localparam logic [DLY_W-1:0] D_ONE   = DLY_W'(1);

  wr_state_e        state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] post_q, post_d;
  logic [3:0]       nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             drive;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
      post_q  <= '0;
      nib_q   <= 4'h0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    done_o  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (start_i) begin
          nib_d  = nibble_i;
          rs_d   = rs_i;
          post_d = post_delay_i;
          if (quiet_i) begin
            state_d = W_WAIT;
            cnt_d   = post_delay_i - D_ONE;
          end else begin
            state_d = W_SETUP;
            cnt_d   = D_SETUP;
          end
        end
      end
      W_SETUP: begin
        if (cnt_q == '0) begin
          state_d = W_EN;
          cnt_d   = D_EN;
        end else begin
          cnt_d = cnt_q - D_ONE;
        end
      end
      W_EN: begin
        if (cnt_q == '0) begin
          state_d = W_WAIT;
          cnt_d   = post_q - D_ONE;
        end else begin
          cnt_d = cnt_q - D_ONE;
        end
      end
      W_WAIT: begin
        if (cnt_q == '0) begin
          state_d = W_IDLE;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - D_ONE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // RS/D are only presented during setup and E; the bus idles at zero otherwise.
  assign drive    = (state_q == W_SETUP) || (state_q == W_EN);
  assign lcd_e_o  = (state_q == W_EN);
  assign lcd_rs_o = drive & rs_q;
  assign lcd_d_o  = drive ? nib_q : 4'h0;

endmodule

`default_nettype wire

// File: rtl/lcd_instruction_sequencer.sv
// lcd_instruction_sequencer: LCD power-on handshake, then streams BRAM commands/characters to a 4-bit LCD.
// Rev 1.0
`default_nettype none

module lcd_instruction_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERON    = 750000,
  parameter int T_INIT_LONG  = 205000,
  parameter int T_INIT_SHORT = 5000,
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 12,
  parameter int T_GAP        = 50,
  parameter int T_CMD        = 2000,
  parameter int T_CLEAR      = 82000,
  parameter int T_REFRESH    = 50000000,
  parameter int CMD_COUNT    = 5,
  parameter int CHAR_COUNT   = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [10:0] bram_addr_o,
  output logic        bram_en_o,
  input  logic [7:0]  bram_do_i,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [3:0]  lcd_d_o,
  output logic        ready_o
);

  localparam logic [DLY_W-1:0] D_POWERON    = DLY_W'(T_POWERON);
  localparam logic [DLY_W-1:0] D_INIT_LONG  = DLY_W'(T_INIT_LONG);
  localparam logic [DLY_W-1:0] D_INIT_SHORT = DLY_W'(T_INIT_SHORT);
  localparam logic [DLY_W-1:0] D_GAP        = DLY_W'(T_GAP);
  localparam logic [DLY_W-1:0] D_CMD        = DLY_W'(T_CMD);
  localparam logic [DLY_W-1:0] D_CLEAR      = DLY_W'(T_CLEAR);
  localparam logic [DLY_W-1:0] D_REFRESH    = DLY_W'(T_REFRESH);
  localparam logic [6:0]       CMD_A        = 7'(CMD_COUNT);
  localparam logic [6:0]       HALF_A       = 7'(CMD_COUNT + CHAR_COUNT / 2);
  localparam logic [6:0]       LAST_A       = 7'(CMD_COUNT + CHAR_COUNT - 1);

  seq_state_e state_q, state_d;
  logic       issued_q, issued_d;
  logic [1:0] init_idx_q, init_idx_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_rs_q, tx_rs_d;
  logic       insert_q, insert_d;
  logic       ins_done_q, ins_done_d;
  logic       ready_q, ready_d;

  logic             waiting;
  logic             wr_start, wr_quiet, wr_rs, wr_done;
  logic [3:0]       wr_nibble;
  logic [DLY_W-1:0] wr_post;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_PWR_WAIT;
      issued_q   <= 1'b0;
      init_idx_q <= 2'd0;
      addr_q     <= 7'd0;
      byte_q     <= 8'h00;
      tx_byte_q  <= 8'h00;
      tx_rs_q    <= RS_CMD;
      insert_q   <= 1'b0;
      ins_done_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      init_idx_q <= init_idx_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      tx_byte_q  <= tx_byte_d;
      tx_rs_q    <= tx_rs_d;
      insert_q   <= insert_d;
      ins_done_q <= ins_done_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    init_idx_d = init_idx_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    tx_byte_d  = tx_byte_q;
    tx_rs_d    = tx_rs_q;
    insert_d   = insert_q;
    ins_done_d = ins_done_q;
    ready_d    = ready_q;
    waiting    = 1'b0;
    wr_start   = 1'b0;
    wr_quiet   = 1'b0;
    wr_nibble  = 4'h0;
    wr_rs      = RS_CMD;
    wr_post    = D_CMD;
    case (state_q)
      S_PWR_WAIT: begin
        waiting  = 1'b1;
        wr_quiet = 1'b1;
        wr_post  = D_POWERON;
        if (wr_done) state_d = S_INIT;
      end
      S_INIT: begin
        waiting   = 1'b1;
        wr_nibble = init_nibble(init_idx_q);
        case (init_idx_q)
          2'd0:    wr_post = D_INIT_LONG;
          2'd1:    wr_post = D_INIT_SHORT;
          default: wr_post = D_CMD;
        endcase
        if (wr_done) begin
          if (init_idx_q == 2'd3) begin
            addr_d  = 7'd0;
            state_d = S_FETCH;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        byte_d  = bram_do_i;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_SEND_HI;
        if (addr_q < CMD_A) begin
          tx_byte_d = byte_q;
          tx_rs_d   = RS_CMD;
          if (byte_q == 8'h00) state_d = S_CLEAR;
        end else if (!ins_done_q && (addr_q == CMD_A || addr_q == HALF_A)) begin
          // Line address goes out first; the same BRAM byte is decoded again afterwards.
          tx_byte_d = (addr_q == CMD_A) ? DDRAM_LINE0 : DDRAM_LINE1;
          tx_rs_d   = RS_CMD;
          insert_d  = 1'b1;
        end else begin
          tx_byte_d = byte_q;
          tx_rs_d   = RS_DATA;
        end
      end
      S_SEND_HI: begin
        waiting   = 1'b1;
        wr_nibble = tx_byte_q[7:4];
        wr_rs     = tx_rs_q;
        wr_post   = D_GAP;
        if (wr_done) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        waiting   = 1'b1;
        wr_nibble = tx_byte_q[3:0];
        wr_rs     = tx_rs_q;
        wr_post   = D_CMD;
        if (wr_done) state_d = S_ADVANCE;
      end
      S_CLEAR: begin
        waiting  = 1'b1;
        wr_quiet = 1'b1;
        wr_post  = D_CLEAR;
        if (wr_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (insert_q) begin
          insert_d   = 1'b0;
          ins_done_d = 1'b1;
          state_d    = S_DECODE;
        end else begin
          ins_done_d = 1'b0;
          if (addr_q == LAST_A) begin
            ready_d = 1'b1;
            addr_d  = CMD_A;
            state_d = S_REFRESH_WAIT;
          end else begin
            addr_d  = addr_q + 7'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_REFRESH_WAIT: begin
        waiting  = 1'b1;
        wr_quiet = 1'b1;
        wr_post  = D_REFRESH;
        if (wr_done) state_d = S_FETCH;
      end
      default: state_d = S_PWR_WAIT;
    endcase
    // Each waiting state kicks the writer once on entry and holds until it reports done.
    if (waiting) begin
      wr_start = !issued_q;
      issued_d = !wr_done;
    end
  end

  lcd_nibble_writer #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN)
  ) u_writer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (wr_start),
    .quiet_i      (wr_quiet),
    .nibble_i     (wr_nibble),
    .rs_i         (wr_rs),
    .post_delay_i (wr_post),
    .lcd_e_o      (lcd_e_o),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_d_o      (lcd_d_o),
    .done_o       (wr_done)
  );

  assign bram_addr_o = {4'b0000, addr_q};
  assign bram_en_o   = (state_q == S_FETCH);
  assign lcd_rw_o    = 1'b0;
  assign ready_o     = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_instruction_sequencer.sv
// tb_lcd_instruction_sequencer: directed/randomized bench with a transfer-level reference model.
// Rev 1.0
`default_nettype none

module tb_lcd_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] bram_addr;
  logic        bram_en;
  logic [7:0]  bram_do = 8'h00;
  logic        lcd_e, lcd_rs, lcd_rw;
  logic [3:0]  lcd_d;
  logic        ready;

  lcd_instruction_sequencer #(
    .T_POWERON(20), .T_INIT_LONG(10), .T_INIT_SHORT(6), .T_SETUP(2), .T_EN(3),
    .T_GAP(4), .T_CMD(5), .T_CLEAR(30), .T_REFRESH(100), .CMD_COUNT(5), .CHAR_COUNT(32)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bram_addr_o(bram_addr), .bram_en_o(bram_en),
    .bram_do_i(bram_do), .lcd_e_o(lcd_e), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_d_o(lcd_d), .ready_o(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:63];
  always @(posedge clk) if (bram_en) bram_do <= mem[bram_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         rise;
    int         fall;
    logic       rdy;
  } pulse_t;

  pulse_t pq[$];
  int     fa[$];
  int     ft[$];

  // Bus monitor: records every completed E pulse and each BRAM fetch, checks strobe shape.
  logic       in_pulse = 1'b0, stable = 1'b1;
  logic       p_rs;
  logic [3:0] p_d;
  int         p_rise, e_run = 0, en_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
      e_run    = 0;
      en_run   = 0;
    end else begin
      if (lcd_e) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          p_rs = lcd_rs; p_d = lcd_d; p_rise = cyc; e_run = 0; stable = 1'b1;
        end else if (lcd_rs !== p_rs || lcd_d !== p_d) begin
          stable = 1'b0;
        end
        e_run++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("e_width", e_run, 3);
        check("rs_d_stable_during_e", {31'd0, stable}, 1);
        check("rw_low", {31'd0, lcd_rw}, 0);
        pq.push_back('{rs: p_rs, d: p_d, rise: p_rise, fall: cyc, rdy: ready});
      end
      if (bram_en) begin
        if (en_run == 0) begin
          fa.push_back(int'(bram_addr));
          ft.push_back(cyc);
        end
        en_run++;
      end else if (en_run > 0) begin
        check("bram_en_single", en_run, 1);
        en_run = 0;
      end
    end
  end

  // Reference model: the ordered list of {rs, byte} transfers one pass must produce.
  logic [8:0] exp_q[$];
  task automatic build_pass(input bit with_cmds);
    exp_q.delete();
    if (with_cmds)
      for (int i = 0; i < 5; i++)
        if (mem[i] != 8'h00) exp_q.push_back({1'b0, mem[i]});
    for (int k = 0; k < 32; k++) begin
      if (k == 0)  exp_q.push_back({1'b0, 8'h80});
      if (k == 16) exp_q.push_back({1'b0, 8'hC0});
      exp_q.push_back({1'b1, mem[5 + k]});
    end
  endtask

  task automatic compare_bytes(input int base);
    for (int j = 0; j < exp_q.size(); j++) begin
      if (base + 2 * j + 1 < pq.size())
        check($sformatf("xfer%0d", j),
              {22'd0, pq[base+2*j].rs, pq[base+2*j+1].rs, pq[base+2*j].d, pq[base+2*j+1].d},
              {22'd0, exp_q[j][8], exp_q[j][8], exp_q[j][7:0]});
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int t = 0;
    while (pq.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("pulse_count", pq.size(), n);
  endtask

  task automatic check_init(input int rel);
    int gaps[3] = '{10, 6, 5};
    if (pq.size() >= 4) begin
      check("poweron_quiet", {31'd0, (pq[0].rise - rel) >= 20}, 1);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("init_nib%0d", i), {27'd0, pq[i].rs, pq[i].d}, (i == 3) ? 32'h2 : 32'h3);
        check($sformatf("init_rdy%0d", i), {31'd0, pq[i].rdy}, 0);
      end
      for (int i = 0; i < 3; i++)
        check($sformatf("init_gap%0d", i), {31'd0, (pq[i+1].rise - pq[i].fall) >= gaps[i]}, 1);
    end
  endtask

  initial begin
    int rel, t, rdy_cyc, nf;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h28; mem[1] = 8'h06; mem[2] = 8'h0C; mem[3] = 8'h01; mem[4] = 8'h00;
    for (int k = 0; k < 32; k++) mem[5 + k] = 8'(8'h41 + k);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {12'd0, lcd_e, lcd_rs, lcd_rw, lcd_d, bram_en, ready, bram_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;

    wait_pulses(4, 500);
    check_init(rel);

    build_pass(1);
    wait_pulses(4 + 2 * exp_q.size(), 4000);
    if (pq.size() >= 80) begin
      check("clear_silence", {31'd0, (pq[12].rise - pq[11].fall) >= 30}, 1);
      check("ready_low_at_last_char", {31'd0, pq[79].rdy}, 0);
    end
    compare_bytes(4);

    t = 0;
    while (!ready && t < 100) begin @(posedge clk); #1; t++; end
    check("ready_rise", {31'd0, ready}, 1);
    rdy_cyc = cyc;
    nf = fa.size();

    for (int k = 0; k < 32; k++) mem[5 + k] = 8'($urandom_range(32, 126));
    build_pass(0);

    t = 0;
    while (fa.size() <= nf && t < 400) begin @(posedge clk); t++; end
    check("refresh_fetch_seen", {31'd0, fa.size() > nf}, 1);
    if (fa.size() > nf) begin
      check("refresh_addr", fa[nf], 5);
      check("refresh_idle", {31'd0, (ft[nf] - rdy_cyc) >= 100}, 1);
    end

    wait_pulses(80 + 2 * exp_q.size(), 3000);
    if (pq.size() > 80) check("refresh_no_e", {31'd0, (pq[80].rise - rdy_cyc) >= 100}, 1);
    compare_bytes(80);
    check("ready_held", {31'd0, ready}, 1);

    t = 0;
    while (!(lcd_e && lcd_rs) && t < 3000) begin @(posedge clk); #1; t++; end
    check("char_e_seen", {31'd0, lcd_e && lcd_rs}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_abort", {24'd0, lcd_e, ready, lcd_rs, bram_en, lcd_d}, 0);
    rst = 1'b0;
    rel = cyc;
    pq.delete();
    wait_pulses(4, 500);
    check_init(rel);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
